// File: rtl/line_buffer_sequencer.sv
// line_buffer_sequencer: frame controller feeding the 3x3 convolution line-buffer shift register
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif
module line_buffer_sequencer #(
    parameter int FEATURE_WIDTH = `FEATURE_WIDTH,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                       system_clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [9:0]                 row_size,
    input  logic [9:0]                 frame_rows,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [FEATURE_WIDTH*2-1:0] in_data,
    output logic                       sr_wr_en,
    output logic [FEATURE_WIDTH*2-1:0] sr_wr_data,
    output logic [9:0]                 sr_shift_size,
    output logic                       win_valid,
    output logic [9:0]                 win_row,
    output logic [9:0]                 win_col,
    output logic                       busy,
    output logic                       frame_done
);
    typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    state_t state, state_nx;
    logic [9:0] cfg_row, cfg_rows, row, col;
    logic [3:0] flush_cnt;
    logic xfer, col_last, row_last, win_hit;
    assign in_ready = state == FILL || state == RUN;
    assign xfer = in_valid && in_ready;
    assign sr_wr_en = xfer;
    assign sr_wr_data = in_data;
    assign busy = state != IDLE;
    assign frame_done = state == DONE;
    assign col_last = col == cfg_row - 10'd1;
    assign row_last = row == cfg_rows - 10'd1;
    // A window's bottom-right pixel is the one being written now
    assign win_hit = xfer && row >= 10'd2 && col >= 10'd2;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = (row_size >= 10'd3 && frame_rows >= 10'd3) ? FILL : DONE;
            FILL:  if (xfer && col_last && row == 10'd1) state_nx = RUN;
            RUN:   if (xfer && col_last && row_last) state_nx = FLUSH;
            FLUSH: if (flush_cnt == FLUSH_LAST) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cfg_row <= '0;
            cfg_rows <= '0;
            row <= '0;
            col <= '0;
            flush_cnt <= '0;
            sr_shift_size <= '0;
            win_valid <= 1'b0;
            win_row <= '0;
            win_col <= '0;
        end else begin
            state <= state_nx;
            win_valid <= win_hit;
            flush_cnt <= state == FLUSH ? flush_cnt + 4'd1 : 4'd0;
            if (state == IDLE && start) begin
                cfg_row <= row_size;
                cfg_rows <= frame_rows;
                sr_shift_size <= row_size;
                row <= '0;
                col <= '0;
            end else if (xfer) begin
                col <= col_last ? 10'd0 : col + 10'd1;
                if (col_last) row <= row + 10'd1;
            end
            if (win_hit) begin
                win_row <= row - 10'd2;
                win_col <= col - 10'd2;
            end
        end
    end
endmodule

// File: tb/tb_line_buffer_sequencer.sv
// tb_line_buffer_sequencer: scoreboard bench for the line-buffer frame sequencer
module tb_line_buffer_sequencer;
    localparam int FW = 8;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [9:0] row_size = '0, frame_rows = '0;
    logic [FW*2-1:0] in_data = '0;
    logic in_ready, sr_wr_en, win_valid, busy, frame_done;
    logic [FW*2-1:0] sr_wr_data;
    logic [9:0] sr_shift_size, win_row, win_col;
    int compared = 0, mism = 0;
    int wr_cnt = 0, win_cnt = 0, first_win = -1;
    logic [19:0] last_win = '0;
    logic [19:0] sb[$];

    line_buffer_sequencer #(.FEATURE_WIDTH(FW), .FLUSH_CYCLES(2)) dut (
        .system_clk(clk), .rst_n(rst_n), .start(start), .row_size(row_size),
        .frame_rows(frame_rows), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sr_wr_en(sr_wr_en), .sr_wr_data(sr_wr_data),
        .sr_shift_size(sr_shift_size), .win_valid(win_valid), .win_row(win_row),
        .win_col(win_col), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Window scoreboard: every DUT window must match the oldest expected one
    always @(negedge clk) begin
        if (win_valid) begin
            logic [19:0] exp_w;
            win_cnt++;
            if (first_win < 0) first_win = wr_cnt;
            last_win = {win_row, win_col};
            compared++;
            if (sb.size() == 0) begin
                mism++;
                $display("FAIL win_unexpected: got row=%0d col=%0d, expected no window", win_row, win_col);
            end else begin
                exp_w = sb.pop_front();
                if ({win_row, win_col} !== exp_w) begin
                    mism++;
                    $display("FAIL win_pos: got (%0d,%0d) expected (%0d,%0d)", win_row, win_col, exp_w[19:10], exp_w[9:0]);
                end
            end
        end
        if (sr_wr_en) wr_cnt++;
    end

    task automatic drive_start(input int rs, input int fr);
        @(posedge clk); #1;
        start = 1'b1; row_size = 10'(rs); frame_rows = 10'(fr);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_beats(input int rs, input int fr, input bit tog, input int restart_at, input int abort_at);
        int k = 0, cyc = 0, r, c;
        while (k < rs * fr && k != abort_at) begin
            in_valid = tog ? (cyc % 2 == 0) : 1'b1;
            in_data = (FW*2)'($urandom);
            start = (cyc == restart_at);
            if (start) row_size = 10'd9;
            @(negedge clk);
            compared++;
            if (sr_wr_en !== in_valid) begin
                mism++;
                $display("FAIL wr_en beat %0d: got %0b expected %0b", k, sr_wr_en, in_valid);
            end
            if (in_valid) begin
                compared++;
                if (in_ready !== 1'b1 || sr_wr_data !== in_data) begin
                    mism++;
                    $display("FAIL wr_data beat %0d: ready=%0b data=%h expected ready=1 data=%h", k, in_ready, sr_wr_data, in_data);
                end
                r = k / rs; c = k % rs;
                if (r >= 2 && c >= 2) sb.push_back({10'(r - 2), 10'(c - 2)});
                k++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_frame(input int rs, input int fr, input bit tog, input int restart_at);
        int n = 1;
        wr_cnt = 0; win_cnt = 0; first_win = -1;
        drive_start(rs, fr);
        drive_beats(rs, fr, tog, restart_at, -1);
        @(negedge clk);
        while (!frame_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n != 3 || busy !== 1'b1) begin
            mism++;
            $display("FAIL done_latency %0dx%0d: got %0d cycles busy=%0b expected 3 busy=1", rs, fr, n, busy);
        end
        @(posedge clk); #1;
        compared++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            mism++;
            $display("FAIL idle_after_done: busy=%0b done=%0b expected 0 0", busy, frame_done);
        end
        compared++;
        if (wr_cnt != rs * fr || win_cnt != (rs - 2) * (fr - 2) || sb.size() != 0) begin
            mism++;
            $display("FAIL frame_counts %0dx%0d: writes=%0d windows=%0d left=%0d expected %0d %0d 0",
                     rs, fr, wr_cnt, win_cnt, sb.size(), rs * fr, (rs - 2) * (fr - 2));
        end
        compared++;
        if (first_win != 2 * rs + 3 || sr_shift_size !== 10'(rs)) begin
            mism++;
            $display("FAIL first_win_shift: first after %0d writes shift=%0d expected %0d %0d",
                     first_win, sr_shift_size, 2 * rs + 3, rs);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        #3;
        compared++;
        if ({in_ready, sr_wr_en, win_valid, busy, frame_done} !== 5'b0 ||
            {win_row, win_col, sr_shift_size} !== 30'b0) begin
            mism++;
            $display("FAIL reset_state: ready=%0b wr=%0b win=%0b busy=%0b done=%0b row=%0d col=%0d shift=%0d expected all 0",
                     in_ready, sr_wr_en, win_valid, busy, frame_done, win_row, win_col, sr_shift_size);
        end
        #19 rst_n = 1'b1;
    endtask

    task automatic test_full_frame();
        run_frame(5, 4, 1'b0, -1);
    endtask

    task automatic test_toggle_valid();
        run_frame(5, 4, 1'b1, -1);
    endtask

    task automatic test_degenerate();
        wr_cnt = 0; win_cnt = 0;
        in_valid = 1'b1;
        drive_start(2, 8);
        @(negedge clk);
        compared++;
        if (busy !== 1'b1 || frame_done !== 1'b1 || in_ready !== 1'b0 || sr_shift_size !== 10'd2) begin
            mism++;
            $display("FAIL degenerate_done: busy=%0b done=%0b ready=%0b shift=%0d expected 1 1 0 2",
                     busy, frame_done, in_ready, sr_shift_size);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || wr_cnt != 0 || win_cnt != 0) begin
            mism++;
            $display("FAIL degenerate_after: busy=%0b done=%0b writes=%0d windows=%0d expected 0 0 0 0",
                     busy, frame_done, wr_cnt, win_cnt);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_restart_ignored();
        run_frame(5, 4, 1'b0, 12);
    endtask

    task automatic test_reset_mid_frame();
        int done_seen = 0;
        wr_cnt = 0; win_cnt = 0;
        drive_start(5, 4);
        drive_beats(5, 4, 1'b0, -1, 10);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({in_ready, sr_wr_en, win_valid, busy, frame_done} !== 5'b0 ||
            {win_row, win_col, sr_shift_size} !== 30'b0) begin
            mism++;
            $display("FAIL async_reset: ready=%0b wr=%0b win=%0b busy=%0b done=%0b shift=%0d expected all 0",
                     in_ready, sr_wr_en, win_valid, busy, frame_done, sr_shift_size);
        end
        repeat (4) begin
            @(negedge clk);
            if (frame_done || busy) done_seen++;
        end
        compared++;
        if (done_seen != 0 || wr_cnt != 10 || win_cnt != 0) begin
            mism++;
            $display("FAIL abandoned_frame: active=%0d writes=%0d windows=%0d expected 0 10 0", done_seen, wr_cnt, win_cnt);
        end
        sb.delete();
        #2 rst_n = 1'b1;
        run_frame(5, 4, 1'b0, -1);
    endtask

    task automatic test_wide_row();
        run_frame(1023, 3, 1'b0, -1);
        compared++;
        if (last_win !== {10'd0, 10'd1020}) begin
            mism++;
            $display("FAIL wide_last_win: got (%0d,%0d) expected (0,1020)", last_win[19:10], last_win[9:0]);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_toggle_valid();
        test_degenerate();
        test_restart_ignored();
        test_reset_mid_frame();
        test_wide_row();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule

// File: doc/line_buffer_sequencer.md
Name: line_buffer_sequencer

Overview:
- Frame-level controller for the RAM-based convolution line-buffer (shift register) cache.
- Accepts a raster stream of packed feature pairs over a valid/ready handshake and drives the shift register's write enable, data and shift size.
- Tracks row and column position and flags every cycle on which a complete 3x3 window is present.
- Sits between the feature-fetch stage and the convolution window/MAC array; issues a frame-done pulse to the layer scheduler.

Parameters:
- FEATURE_WIDTH, `FEATURE_WIDTH: width of one feature; data path is FEATURE_WIDTH*2.
- FLUSH_CYCLES, 2: idle cycles after the last pixel so the shift-register read pipeline drains (1..15).

Ports:
- system_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame start; honoured only in IDLE
- row_size  in  10  pixels per row; sampled on start
- frame_rows  in  10  rows per frame; sampled on start
- in_valid  in  1  upstream data valid
- in_ready  out  1  sequencer can accept
- in_data  in  FEATURE_WIDTH*2  packed feature pair
- sr_wr_en  out  1  shift register write enable
- sr_wr_data  out  FEATURE_WIDTH*2  shift register write data
- sr_shift_size  out  10  shift register delay configuration
- win_valid  out  1  a complete 3x3 window is available this cycle
- win_row  out  10  top-left row of the window
- win_col  out  10  top-left column of the window
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle end-of-frame pulse

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is system_clk. On reset: state=IDLE; counters and config registers=0; in_ready, win_valid, busy, frame_done=0; win_row, win_col, sr_shift_size=0.
- States are IDLE, FILL, RUN, FLUSH, DONE.
- IDLE:
  - start=1 latches cfg_row=row_size and cfg_rows=frame_rows.
  - If cfg_row>=3 and cfg_rows>=3, go to FILL.
  - Otherwise go straight to DONE. No input is accepted and no window is produced.
- busy=1 in every state except IDLE. start outside IDLE is ignored.
- sr_shift_size is registered: it is loaded with row_size on an accepted start and held until the next accepted start.
- Handshake:
  - in_ready=1 combinationally in FILL and RUN, 0 otherwise.
  - A transfer occurs when in_valid && in_ready.
  - sr_wr_en = transfer, combinational.
  - sr_wr_data = in_data, combinational pass-through.
  - No writes occur in any other state.
- Counters col (0..cfg_row-1) and row (0..cfg_rows-1) advance only on a transfer.
  - col wraps to 0 at cfg_row-1, and row increments on that wrap.
  - A cycle with in_valid=0 holds all state.
- FILL -> RUN on the transfer that moves row from 1 to 2.
- Window flag:
  - win_valid is registered, 1 cycle after a transfer whose pre-increment (row, col) has row>=2 and col>=2.
  - On that cycle win_row=row-2 and win_col=col-2. Both hold their value when win_valid=0.
  - Windows per frame = (cfg_row-2)*(cfg_rows-2).
- RUN -> FLUSH on the transfer at row=cfg_rows-1, col=cfg_row-1. Call that transfer cycle T.
  - FLUSH lasts FLUSH_CYCLES cycles (T+1..T+FLUSH_CYCLES).
  - Then DONE for one cycle (T+FLUSH_CYCLES+1), with frame_done=1.
  - Then IDLE.
  - The final win_valid, at T+1, overlaps FLUSH.
- A start in the DONE cycle is ignored.
- Reset mid-frame returns to IDLE immediately. The partial frame is abandoned; no frame_done and no win_valid.
- Counter widths: all comparisons are 10-bit unsigned. The maximum legal value of row_size and frame_rows is 1023.

Test Plan:
- row_size=5, frame_rows=4, in_valid held 1:
  - 20 sr_wr_en pulses.
  - win_valid on 6 cycles, at (row,col)=(0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - First win_valid 1 cycle after the 13th transfer.
  - frame_done 3 cycles after the 20th transfer; sr_shift_size=5.
- Same frame with in_valid toggling 1,0,1,0,...:
  - Identical win_row/win_col sequence and counts.
  - No sr_wr_en while in_valid=0.
  - frame_done 3 cycles after the last transfer.
- row_size=2, frame_rows=8, start:
  - busy for 1 cycle, then frame_done.
  - in_ready never 1, zero sr_wr_en, zero win_valid.
- start pulsed again mid-frame (in RUN) with row_size=9:
  - Ignored; sr_shift_size stays 5.
  - Window count and positions are unchanged.
- rst_n low after the 10th transfer:
  - All outputs 0 asynchronously; no frame_done.
  - A subsequent start with 5x4 completes normally with 6 windows.
- row_size=1023, frame_rows=3:
  - 1021 windows, all with win_row=0.
  - Last window has win_col=1020, with no counter overflow.
